e1_byte_mux: RTL and testbench
==============================

E1_BYTE_MUX -- requirements
Module: e1_byte_mux

Interface
REQ-001 Parameter NCH, default 21, number of E1 tributaries; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock for all logic.
REQ-003 rst  input  1  reset: synchronous, active-high, on clock clk.
REQ-004 e1_bit  input  NCH  serial E1 data, one bit per channel; bit ch belongs to channel ch.
REQ-005 e1_vld  input  NCH  per-channel bit strobe; e1_bit[ch] is sampled only when e1_vld[ch]=1.
REQ-006 ovf_clr  input  1  single-cycle pulse that clears all sticky overflow flags.
REQ-007 di_vld  output  1  registered strobe marking one valid byte toward the TU-12 generator bank.
REQ-008 oid  output  5  registered channel index of the byte; valid when di_vld=1.
REQ-009 datain  output  8  registered byte for channel oid; valid when di_vld=1.
REQ-010 ovf  output  NCH  sticky per-channel overflow flags.

Function
REQ-011 Each channel shall keep an 8-bit shift register sh, a 3-bit bit counter cnt, an 8-bit holding register hold and a pending flag pend.
REQ-012 On e1_vld[ch]=1: sh <= {sh[6:0], e1_bit[ch]} and cnt <= cnt+1 (the first received bit is the MSB).
REQ-013 On e1_vld[ch]=1 with cnt=7: hold <= {sh[6:0], e1_bit[ch]}, pend <= 1, cnt wraps to 0.
REQ-014 The scan pointer ptr shall advance by 1 every clock cycle, wrapping from NCH-1 to 0, independent of pend.
REQ-015 When pend[ptr]=1 at a clock edge: di_vld <= 1, oid <= ptr, datain <= hold[ptr], and pend[ptr] <= 0.
REQ-016 When pend[ptr]=0: di_vld <= 0; oid and datain keep their previous values.
REQ-017 At most one byte shall be issued per cycle, and only the channel under ptr is ever served.
REQ-018 Latency from the byte-completing edge to di_vld high shall be 1..NCH+1 cycles (worst case is a completion just after ptr has passed the channel).
REQ-019 If a completion for a channel and its service happen at the same edge, the old hold value shall be issued, the new byte shall be loaded, and pend shall remain 1; this is not an overflow.
REQ-020 If a completion happens while pend=1 and the channel is not being served, hold shall be overwritten with the new byte, pend shall stay 1, and this shall count as an overflow (REQ-028).
REQ-021 Channels shall be fully independent: simultaneous e1_vld on any subset of channels is legal.
REQ-022 e1_vld for a channel index at or above NCH does not exist; oid values at or above NCH shall never be produced.

Reset
REQ-023 rst=1 shall clear sh, cnt, hold and pend for every channel, and shall set ptr=0, di_vld=0, oid=0, datain=0 and ovf=0.
REQ-024 Reset applied mid-byte shall discard partial bits; the next e1_vld after reset shall be captured as the MSB.
REQ-025 Reset shall take priority over every other event in the same cycle.

Configuration
REQ-026 Macro E1_BYTE_MUX_OVF_STATUS_EN selects whether overflow status is compiled in.
REQ-027 Without E1_BYTE_MUX_OVF_STATUS_EN: ovf shall be constant 0, ovf_clr shall be ignored, and the overwrite behaviour of REQ-020 is unchanged.
REQ-028 With E1_BYTE_MUX_OVF_STATUS_EN: an overflow event sets ovf[ch] <= 1, which holds until ovf_clr=1; set takes priority over ovf_clr in the same cycle.

Verification
REQ-029 NCH=21; channel 0 receives bits 1,0,1,0,0,1,0,1 on consecutive cycles -> exactly one di_vld pulse, oid=0, datain=8'hA5, within 22 cycles of the 8th bit.
REQ-030 All 21 channels complete byte 8'h00+ch on the same edge -> 21 di_vld pulses on consecutive cycles, oid in ascending cyclic order starting at ptr, each datain equal to its oid; ovf=0.
REQ-031 Channel 5 completes 8'h11, then completes 8'h22 before ptr reaches 5 -> a single issue with oid=5, datain=8'h22; with the macro ovf[5]=1, without it ovf[5]=0.
REQ-032 With ovf[5]=1, pulse ovf_clr -> ovf[5]=0 next cycle; pulse ovf_clr on the same cycle as a new overflow on channel 5 -> ovf[5] stays 1.
REQ-033 rst asserted after 4 bits on channel 3, then 8 bits 8'hFF sent -> one byte issued with oid=3, datain=8'hFF; no byte from the partial data ever appears.
REQ-034 Channel 7 completes 8'h3C on the same edge that ptr=7 serves pending 8'h C3 -> 8'hC3 issued now; 8'h3C issued on the next lap exactly NCH cycles later; ovf[7]=0.

Source files
------------

// File: rtl/e1_byte_mux.sv
// e1_byte_mux
//   Collects serial E1 tributary bits into bytes, one independent deserialiser
//   per channel, and multiplexes the finished bytes onto a single byte bus
//   feeding the TU-12 generator bank. A free-running scan pointer visits one
//   channel per clock; a channel with a pending byte is served when the
//   pointer lands on it.
//
//   Optional feature: define E1_BYTE_MUX_OVF_STATUS_EN to compile in the
//   sticky per-channel overflow flags. Without it ovf is tied to zero and
//   ovf_clr is ignored. Overwrite of an unserved byte happens either way.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   e1_bit   [NCH] serial data, bit ch belongs to channel ch (first bit = MSB)
//   e1_vld   [NCH] per-channel bit strobe
//   ovf_clr  pulse clearing all sticky overflow flags
//   di_vld   strobe: one byte presented on oid/datain
//   oid      [5]   channel index of the byte
//   datain   [8]   byte payload
//   ovf      [NCH] sticky overflow flags
module e1_byte_mux #(
  parameter int NCH = 21
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] e1_bit,
  input  logic [NCH-1:0] e1_vld,
  input  logic           ovf_clr,
  output logic           di_vld,
  output logic [4:0]     oid,
  output logic [7:0]     datain,
  output logic [NCH-1:0] ovf
);

  logic [7:0]     sh   [NCH];
  logic [2:0]     cnt  [NCH];
  logic [7:0]     hold [NCH];
  logic [NCH-1:0] pend;
  logic [4:0]     ptr;

  logic [NCH-1:0] done;
  logic [NCH-1:0] serve;
  logic [NCH-1:0] ovf_evt;
  logic [7:0]     hold_sel;
  logic           pend_sel;

  // A completion on a channel that is being served in the same cycle is not
  // an overflow: the old byte leaves on the bus while the new one is loaded.
  always_comb begin
    done     = '0;
    serve    = '0;
    ovf_evt  = '0;
    hold_sel = '0;
    pend_sel = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      done[ch]    = e1_vld[ch] && (cnt[ch] == 3'd7);
      serve[ch]   = pend[ch] && (ptr == 5'(ch));
      ovf_evt[ch] = done[ch] && pend[ch] && !serve[ch];
      if (ptr == 5'(ch)) begin
        hold_sel = hold[ch];
        pend_sel = pend[ch];
      end
    end
  end

  // Per-channel deserialisers and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        sh[ch]   <= '0;
        cnt[ch]  <= '0;
        hold[ch] <= '0;
      end
      pend <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (e1_vld[ch]) begin
          sh[ch]  <= {sh[ch][6:0], e1_bit[ch]};
          cnt[ch] <= cnt[ch] + 3'd1;
        end
        if (done[ch]) begin
          hold[ch] <= {sh[ch][6:0], e1_bit[ch]};
          pend[ch] <= 1'b1;
        end else if (serve[ch]) begin
          pend[ch] <= 1'b0;
        end
      end
    end
  end

  // Scan pointer and registered output bus; oid/datain hold between bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      di_vld <= 1'b0;
      oid    <= '0;
      datain <= '0;
    end else begin
      ptr    <= (ptr == 5'(NCH - 1)) ? 5'd0 : ptr + 5'd1;
      di_vld <= pend_sel;
      if (pend_sel) begin
        oid    <= ptr;
        datain <= hold_sel;
      end
    end
  end

`ifdef E1_BYTE_MUX_OVF_STATUS_EN
  // Sticky flags: a new overflow wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (ovf_evt[ch]) begin
          ovf[ch] <= 1'b1;
        end else if (ovf_clr) begin
          ovf[ch] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, ovf_evt};
  assign ovf        = '0;
`endif

endmodule

// File: tb/tb_e1_byte_mux.sv
// tb_e1_byte_mux
//   Scoreboard bench for e1_byte_mux (NCH=21). The driver applies one input
//   vector per clock and feeds the same vector to a behavioural model that
//   assembles bytes from bit counts and arithmetic, tracks one pending byte
//   per channel and a scan position equal to the cycle count modulo NCH.
//   For every clock edge the model pushes the expected bus state; a monitor
//   pops one entry per cycle and compares di_vld, oid, datain and ovf.
module tb_e1_byte_mux;
  localparam int NCH = 21;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] e1_bit = '0;
  logic [NCH-1:0] e1_vld = '0;
  logic           ovf_clr = 1'b0;
  logic           di_vld;
  logic [4:0]     oid;
  logic [7:0]     datain;
  logic [NCH-1:0] ovf;

  e1_byte_mux #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .e1_bit(e1_bit), .e1_vld(e1_vld),
    .ovf_clr(ovf_clr), .di_vld(di_vld), .oid(oid), .datain(datain), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           vld;
    logic [4:0]     oid;
    logic [7:0]     dat;
    logic [NCH-1:0] ovf;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Behavioural model state
  int             nbits [NCH];
  int             acc   [NCH];
  int             pbyte [NCH];
  bit             pvalid[NCH];
  bit             ovm   [NCH];
  int             ptr_m = 0;
  int             last_oid = 0;
  int             last_dat = 0;
  int             n_ovf_events = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                            input logic c, input logic r);
    exp_t e;
    bit   ovset[NCH];
    e.vld = 1'b0;
    if (r) begin
      for (int ch = 0; ch < NCH; ch++) begin
        nbits[ch] = 0; acc[ch] = 0; pbyte[ch] = 0; pvalid[ch] = 0; ovm[ch] = 0;
      end
      ptr_m = 0; last_oid = 0; last_dat = 0;
    end else begin
      // the channel under the scan position releases its byte first
      if (pvalid[ptr_m]) begin
        e.vld = 1'b1;
        last_oid = ptr_m;
        last_dat = pbyte[ptr_m];
        pvalid[ptr_m] = 0;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        ovset[ch] = 0;
        if (v[ch]) begin
          acc[ch] = acc[ch] * 2 + int'(b[ch]);
          nbits[ch]++;
          if (nbits[ch] == 8) begin
            if (pvalid[ch]) begin
              ovset[ch] = 1;
              n_ovf_events++;
            end
            pbyte[ch]  = acc[ch];
            pvalid[ch] = 1;
            acc[ch]    = 0;
            nbits[ch]  = 0;
          end
        end
        if (ovset[ch]) ovm[ch] = 1;
        else if (c)    ovm[ch] = 0;
      end
      ptr_m = (ptr_m + 1) % NCH;
    end
    e.oid = 5'(last_oid);
    e.dat = 8'(last_dat);
    e.ovf = '0;
`ifdef E1_BYTE_MUX_OVF_STATUS_EN
    for (int ch = 0; ch < NCH; ch++) e.ovf[ch] = ovm[ch];
`endif
    q.push_back(e);
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                       input logic c, input logic r);
    e1_vld = v; e1_bit = b; ovf_clr = c; rst = r;
    model_edge(v, b, c, r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input int ch, input logic [7:0] byt, input logic clr_last);
    logic [NCH-1:0] v;
    logic [NCH-1:0] b;
    for (int i = 0; i < 8; i++) begin
      v = '0; b = '0;
      v[ch] = 1'b1;
      b[ch] = byt[7-i];
      drive(v, b, clr_last && (i == 7), 1'b0);
    end
  endtask

  task automatic wait_ptr(input int p);
    for (int k = 0; k < NCH && ptr_m != p; k++) idle(1);
  endtask

  task automatic rand_phase(input int ncyc, input int vld_den);
    logic [NCH-1:0] v;
    logic [NCH-1:0] b;
    for (int i = 0; i < ncyc; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        v[ch] = ($urandom_range(0, vld_den - 1) == 0);
        b[ch] = 1'($urandom);
      end
      drive(v, b, $urandom_range(0, 31) == 0, $urandom_range(0, 699) == 0);
    end
  endtask

  // Monitor: one expected entry per clock, sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: DUT cycle %0d has no expected entry", cyc);
      end else begin
        e = q.pop_front();
        chk("di_vld", 32'(di_vld), 32'(e.vld));
        chk("oid",    32'(oid),    32'(e.oid));
        chk("datain", 32'(datain), 32'(e.dat));
        chk("ovf",    32'(ovf),    32'(e.ovf));
      end
    end
  end

  initial begin
    logic [NCH-1:0] v;
    logic [NCH-1:0] b;
    logic [7:0]     byt;

    // reset
    for (int i = 0; i < 3; i++) drive('0, '0, 1'b0, 1'b1);
    idle(2);

    // single byte A5 on channel 0
    send_byte(0, 8'hA5, 1'b0);
    idle(NCH + 4);

    // all channels complete byte = channel index on the same edge
    for (int i = 0; i < 8; i++) begin
      v = '1; b = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        byt = 8'(ch);
        b[ch] = byt[7-i];
      end
      drive(v, b, 1'b0, 1'b0);
    end
    idle(NCH + 4);

    // overflow on channel 5: 11 then 22 before the scan reaches it
    wait_ptr(6);
    send_byte(5, 8'h11, 1'b0);
    send_byte(5, 8'h22, 1'b0);
    idle(NCH + 2);
    // clear, then overflow again with a clear on the same edge
    drive('0, '0, 1'b1, 1'b0);
    idle(2);
    wait_ptr(6);
    send_byte(5, 8'h33, 1'b0);
    send_byte(5, 8'h44, 1'b1);
    idle(NCH + 2);
    drive('0, '0, 1'b1, 1'b0);
    idle(2);

    // reset in the middle of a byte on channel 3
    send_byte(3, 8'hFF, 1'b0);
    idle(NCH + 2);
    v = '0; b = '0; v[3] = 1'b1; b[3] = 1'b0;
    for (int i = 0; i < 4; i++) drive(v, b, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b1);
    send_byte(3, 8'hFF, 1'b0);
    idle(NCH + 2);

    // completion on channel 7 on the edge that serves its pending byte
    wait_ptr(8);
    send_byte(7, 8'hC3, 1'b0);
    wait_ptr(0);
    send_byte(7, 8'h3C, 1'b0);
    idle(NCH + 4);

    // randomized traffic: sparse, then dense enough to overflow
    rand_phase(1500, 10);
    rand_phase(800, 3);
    rand_phase(400, 1);
    idle(NCH + 4);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
